// File: rtl/fixmul_pipe.sv
// Pipelined signed fixed-point multiplier with selectable rounding and overflow counting.
// Define FIXMUL_SAT_EN to clamp overflowing results instead of wrapping them.
module fixmul_pipe #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FRAC_BITS  = 10,
    parameter int unsigned STAGES     = 3,
    parameter int unsigned ROUND_MODE = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_p,
    output logic              out_ovf,
    input  logic              ovf_clr,
    output logic [15:0]       ovf_count
);

    // One spare bit so the rounding add can never wrap the full product.
    localparam int unsigned PW = 2 * DATA_W + 1;

    logic signed [PW-1:0]     a_ext, b_ext, prod, rnd, sum, shifted;
    logic [DATA_W+1:0]        top;
    logic                     adv, ovf_next;
    logic [DATA_W-1:0]        p_next;

    logic [DATA_W-1:0]        p_q [STAGES];
    logic [STAGES-1:0]        valid_q, ovf_q;
    logic [15:0]              cnt_q;

    always_comb begin
        a_ext = PW'($signed(in_a));
        b_ext = PW'($signed(in_b));
        prod  = a_ext * b_ext;
        rnd   = '0;
        if (ROUND_MODE == 1) begin
            rnd = PW'(1) << (FRAC_BITS - 1);
        end else if (ROUND_MODE == 2 && prod[PW-1]) begin
            rnd = (PW'(1) << FRAC_BITS) - PW'(1);
        end
        sum      = prod + rnd;
        shifted  = sum >>> FRAC_BITS;
        // In range only when every bit from the result sign upward agrees.
        top      = shifted[PW-1:DATA_W-1];
        ovf_next = !((&top) || !(|top));
`ifdef FIXMUL_SAT_EN
        if (ovf_next) begin
            p_next = shifted[PW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            p_next = shifted[DATA_W-1:0];
        end
`else
        p_next = shifted[DATA_W-1:0];
`endif
    end

    assign adv       = out_ready || !out_valid;
    assign in_ready  = adv;
    assign out_valid = valid_q[STAGES-1];
    assign out_p     = p_q[STAGES-1];
    assign out_ovf   = ovf_q[STAGES-1];
    assign ovf_count = cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            ovf_q   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                p_q[i] <= '0;
            end
        end else if (adv) begin
            valid_q[0] <= in_valid;
            ovf_q[0]   <= ovf_next;
            p_q[0]     <= p_next;
            for (int i = 1; i < STAGES; i++) begin
                valid_q[i] <= valid_q[i-1];
                ovf_q[i]   <= ovf_q[i-1];
                p_q[i]     <= p_q[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (ovf_clr) begin
            cnt_q <= '0;
        end else if (out_valid && out_ready && out_ovf && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_fixmul_pipe.sv
// Directed bench for fixmul_pipe: three instances share stimulus, one per rounding mode.
module tb_fixmul_pipe;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid, out_ready, ovf_clr;
    logic [31:0] in_a, in_b;
    logic        in_ready0, in_ready1, in_ready2;
    logic        out_valid0, out_valid1, out_valid2;
    logic [31:0] p0, p1, p2;
    logic        ovf0, ovf1, ovf2;
    logic [15:0] cnt0, cnt1, cnt2;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    logic [31:0] got [$];
    logic [31:0] held;
    bit          prev_stall, acc;
    int          stall_n, guard, stale, n;

    always #5 clock = ~clock;

    fixmul_pipe #(.DATA_W(32), .FRAC_BITS(10), .STAGES(3), .ROUND_MODE(0)) u_m0 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid0), .out_ready(out_ready),
        .out_p(p0), .out_ovf(ovf0), .ovf_clr(ovf_clr), .ovf_count(cnt0)
    );
    fixmul_pipe #(.DATA_W(32), .FRAC_BITS(10), .STAGES(3), .ROUND_MODE(1)) u_m1 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid1), .out_ready(out_ready),
        .out_p(p1), .out_ovf(ovf1), .ovf_clr(ovf_clr), .ovf_count(cnt1)
    );
    fixmul_pipe #(.DATA_W(32), .FRAC_BITS(10), .STAGES(3), .ROUND_MODE(2)) u_m2 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid2), .out_ready(out_ready),
        .out_p(p2), .out_ovf(ovf2), .ovf_clr(ovf_clr), .ovf_count(cnt2)
    );

    task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    // One isolated transaction: latency, result in all three modes, then counter update.
    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic eovf);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        check({tag, "_lat1"}, out_valid0, 0);
        @(posedge clock); #1;
        check({tag, "_lat2"}, out_valid0, 0);
        @(posedge clock); #1;
        check({tag, "_valid"}, {out_valid0, out_valid1, out_valid2}, 3'b111);
        check({tag, "_p0"}, p0, e0);
        check({tag, "_p1"}, p1, e1);
        check({tag, "_p2"}, p2, e2);
        check({tag, "_ovf"}, {ovf0, ovf1, ovf2}, {3{eovf}});
        if (eovf) exp_cnt++;
        @(posedge clock); #1;
        check({tag, "_cnt"}, cnt0, 64'(exp_cnt));
        check({tag, "_drain"}, out_valid0, 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        in_a      = '0;
        in_b      = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid", out_valid0, 0);
        check("rst_p", p0, 0);
        check("rst_ovf", ovf0, 0);
        check("rst_cnt", cnt0, 0);
        check("rst_ready", in_ready0, 1);
        out_ready = 1'b1;
        reset_n   = 1'b1;

        // 1.5 * 2.0 = 3.0 in Q10; first edge after release accepts it.
        run_one("basic", 32'h600, 32'h800, 32'hC00, 32'hC00, 32'hC00, 1'b0);
        run_one("neg", 32'hFFFFFA00, 32'h800, 32'hFFFFF400, 32'hFFFFF400, 32'hFFFFF400, 1'b0);
        run_one("rnd_m1", 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0);
        run_one("rnd_half", 32'h200, 32'h1, 32'h0, 32'h1, 32'h0, 1'b0);
`ifdef FIXMUL_SAT_EN
        run_one("ovf_max", 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                32'h7FFFFFFF, 1'b1);
        run_one("ovf_min", 32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF,
                32'h7FFFFFFF, 1'b1);
        run_one("ovf_neg", 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h80000000,
                32'h80000000, 1'b1);
`else
        // (2^31-1)^2 >> 10 = 2^52 - 2^22, whose low word is 0xFFC00000.
        run_one("ovf_max", 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFC00000, 32'hFFC00000,
                32'hFFC00000, 1'b1);
        run_one("ovf_min", 32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h0, 1'b1);
        // -2^62 + 2^31 >> 10 = -2^52 + 2^21, low word 0x00200000.
        run_one("ovf_neg", 32'h80000000, 32'h7FFFFFFF, 32'h00200000, 32'h00200000,
                32'h00200000, 1'b1);
`endif

        // Backpressure: six back-to-back pairs, out_ready dropped for five cycles.
        got.delete();
        stall_n    = 0;
        prev_stall = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    in_a     = 32'(i + 1) << 10;
                    in_b     = 32'h0C00;
                    in_valid = 1'b1;
                    acc      = 1'b0;
                    guard    = 0;
                    while (!acc && guard < 20) begin
                        @(negedge clock);
                        acc = in_ready0;
                        @(posedge clock); #1;
                        guard++;
                    end
                end
                in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clock);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clock);
                #1 out_ready = 1'b1;
            end
            begin
                repeat (30) begin
                    @(negedge clock);
                    if (out_valid0 && out_ready) got.push_back(p0);
                    if (out_valid0 && !out_ready) begin
                        stall_n++;
                        check("stall_ready", in_ready0, 0);
                        if (prev_stall) check("stall_hold", p0, held);
                        held       = p0;
                        prev_stall = 1'b1;
                    end else begin
                        prev_stall = 1'b0;
                    end
                end
            end
        join
        check("bp_stalled", stall_n > 0, 1);
        check("bp_count", got.size(), 6);
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            check($sformatf("bp_item%0d", i), got[i], 32'((i + 1) * 3) << 10);
        end

        // Reset with three results in flight.
        @(posedge clock); #1;
        in_a     = 32'h400;
        in_b     = 32'h400;
        in_valid = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("mid_pre_valid", out_valid0, 1);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid_valid", out_valid0, 0);
        check("mid_p", p0, 0);
        check("mid_cnt", cnt0, 0);
        check("mid_ready", in_ready0, 1);
        @(negedge clock);
        reset_n = 1'b1;
        stale   = 0;
        repeat (6) begin
            @(negedge clock);
            if (out_valid0) stale++;
        end
        check("mid_stale", stale, 0);

        // Counter saturation, then clear colliding with an overflow transfer.
        @(posedge clock); #1;
        in_a     = 32'h7FFFFFFF;
        in_b     = 32'h7FFFFFFF;
        in_valid = 1'b1;
        n        = 0;
        while (cnt0 != 16'hFFFF && n < 70000) begin
            @(posedge clock); #1;
            n++;
        end
        check("cnt_reach", cnt0, 16'hFFFF);
        @(posedge clock); #1;
        check("cnt_sat", cnt0, 16'hFFFF);
        check("clr_ovf_live", {out_valid0, ovf0}, 2'b11);
        ovf_clr = 1'b1;
        @(posedge clock); #1;
        check("cnt_clr", cnt0, 0);
        ovf_clr  = 1'b0;
        in_valid = 1'b0;
        repeat (4) @(posedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
